latch_snapshot_streamer: RTL and testbench

//  Parametrised successor to the debug latch-select path: captures all NUM_LATCHES pipeline latch words
//  (IF/DE/EX/ME) in a single cycle, on request or on program halt. Streams the frozen snapshot as framed

---
 rtl/latch_snapshot_streamer_if.sv | 10 +
 rtl/latch_snapshot_streamer.sv | 142 ++++++++++++++
 tb/tb_latch_snapshot_streamer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_snapshot_streamer_if.sv
// Byte stream from the snapshot streamer to the UART transmit side.
// The master drives data/valid and the slave drives ready.
interface latch_snapshot_streamer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, tx_valid, input  tx_ready);
   modport slave  (input  tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/latch_snapshot_streamer.sv
// Freezes all pipeline latch words in one cycle and streams them as a framed byte dump.
// Define SNAPSHOT_CHECKSUM_EN to append an XOR-of-data-bytes checksum byte to each frame.
module latch_snapshot_streamer #(
   parameter int NUM_LATCHES = 16,
   parameter int DATA_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_LATCHES*DATA_W-1:0] latch_bus,
   input  logic                          trigger,
   input  logic                          halt,
   latch_snapshot_streamer_if.master     tx,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);
   localparam int BPW  = (DATA_W + 7) / 8;
   localparam int WI_W = (NUM_LATCHES > 1) ? $clog2(NUM_LATCHES) : 1;
   localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NUM_LATCHES - 1);
   localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPW - 1);
   localparam logic [7:0]      HDR_BYTE  = 8'hA5;
   localparam logic [7:0]      CNT_BYTE  = 8'(NUM_LATCHES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_CNT  = 3'd2,
      S_DATA = 3'd3,
`ifdef SNAPSHOT_CHECKSUM_EN
      S_CSUM = 3'd4,
`endif
      S_DONE = 3'd5
   } state_t;

   state_t                             state, state_nxt;
   logic [NUM_LATCHES-1:0][DATA_W-1:0] shadow;
   logic [WI_W-1:0]                    word_idx;
   logic [BI_W-1:0]                    byte_idx;
   logic                               halt_q;
   logic                               req;
   logic                               xfer;
   logic                               capture;
   logic                               last_data;
   logic [BPW*8-1:0]                   cur_word;
   logic [7:0]                         data_byte;

   // A held halt only requests on its rising edge.
   assign req       = trigger | (halt & ~halt_q);
   assign xfer      = tx.tx_valid & tx.tx_ready;
   assign capture   = (state == S_IDLE) & req;
   assign last_data = (word_idx == LAST_WORD) & (byte_idx == LAST_BYTE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   // Zero-pad the word so bits above DATA_W read as 0 in its last byte.
   always_comb begin
      cur_word             = '0;
      cur_word[DATA_W-1:0] = shadow[word_idx];
      data_byte            = cur_word[byte_idx*8 +: 8];
   end

`ifdef SNAPSHOT_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      csum <= '0;
      else if (capture)                csum <= '0;
      else if (state == S_DATA && xfer) csum <= csum ^ data_byte;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Counters move only on a transfer, so tx_data holds while the sink stalls.
   always_comb begin
      state_nxt   = state;
      tx.tx_valid = 1'b0;
      tx.tx_data  = 8'h00;
      case (state)
         S_IDLE: if (req) state_nxt = S_HDR;
         S_HDR: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = HDR_BYTE;
            if (tx.tx_ready) state_nxt = S_CNT;
         end
         S_CNT: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = CNT_BYTE;
            if (tx.tx_ready) state_nxt = S_DATA;
         end
         S_DATA: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = data_byte;
            if (tx.tx_ready && last_data) begin
`ifdef SNAPSHOT_CHECKSUM_EN
               state_nxt = S_CSUM;
`else
               state_nxt = S_DONE;
`endif
            end
         end
`ifdef SNAPSHOT_CHECKSUM_EN
         S_CSUM: begin
            tx.tx_valid = 1'b1;
            tx.tx_data  = csum;
            if (tx.tx_ready) state_nxt = S_DONE;
         end
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_q   <= 1'b0;
         overrun  <= 1'b0;
         shadow   <= '0;
         word_idx <= '0;
         byte_idx <= '0;
      end else begin
         halt_q <= halt;
         if (req && state != S_IDLE) overrun <= 1'b1;
         if (capture) begin
            shadow   <= latch_bus;
            word_idx <= '0;
            byte_idx <= '0;
         end else if (state == S_DATA && xfer) begin
            if (byte_idx == LAST_BYTE) begin
               byte_idx <= '0;
               word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_latch_snapshot_streamer.sv
// Directed bench for latch_snapshot_streamer: expected frames are queued at stimulus time
// and popped by byte monitors on every valid/ready transfer.
`timescale 1ns/1ps
module tb_latch_snapshot_streamer;
   localparam int NL0 = 16, DW0 = 32, NL1 = 3, DW1 = 12;
`ifdef SNAPSHOT_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int FRAME0 = 2 + NL0 * 4 + CS;
   localparam int FRAME1 = 2 + NL1 * 2 + CS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NL0*DW0-1:0] bus0;
   logic               trig0, halt0, busy0, done0, ovr0;
   logic [NL1*DW1-1:0] bus1;
   logic               trig1, busy1, done1, ovr1;

   latch_snapshot_streamer_if tx0 ();
   latch_snapshot_streamer_if tx1 ();

   latch_snapshot_streamer #(.NUM_LATCHES(NL0), .DATA_W(DW0)) u0 (
      .clk(clk), .rst_n(rst_n), .latch_bus(bus0), .trigger(trig0), .halt(halt0),
      .tx(tx0), .busy(busy0), .done(done0), .overrun(ovr0));

   latch_snapshot_streamer #(.NUM_LATCHES(NL1), .DATA_W(DW1)) u1 (
      .clk(clk), .rst_n(rst_n), .latch_bus(bus1), .trigger(trig1), .halt(1'b0),
      .tx(tx1), .busy(busy1), .done(done1), .overrun(ovr1));

   int          n_chk = 0, n_fail = 0;
   logic [7:0]  q0[$], q1[$];
   logic [31:0] w0 [NL0];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_bus0();
      for (int k = 0; k < NL0; k++) bus0[k*DW0 +: DW0] = w0[k];
   endtask

   task automatic scramble_bus0();
      for (int k = 0; k < NL0; k++) bus0[k*DW0 +: DW0] = $urandom;
   endtask

   task automatic push_frame0();
      logic [7:0] x, cs;
      cs = 8'h00;
      q0.push_back(8'hA5);
      q0.push_back(8'(NL0));
      for (int k = 0; k < NL0; k++)
         for (int b = 0; b < 4; b++) begin
            x = w0[k][b*8 +: 8];
            q0.push_back(x);
            cs = cs ^ x;
         end
      if (CS != 0) q0.push_back(cs);
   endtask

   task automatic pulse_trig0();
      @(posedge clk); #1 trig0 = 1'b1;
      @(posedge clk); #1 trig0 = 1'b0;
   endtask

   // Runs up to budget cycles, counting valid cycles and done pulses.
   task automatic run0(input int budget, input bit rnd, input bit scramble, input bit until_done,
                       output int vc, output int nd);
      vc = 0;
      nd = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx0.tx_valid) vc++;
         if (done0) nd++;
         @(posedge clk); #1;
         tx0.tx_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
         if (scramble) scramble_bus0();
         if (until_done && nd != 0) break;
      end
   endtask

   logic       stall0 = 1'b0, stall1 = 1'b0;
   logic [7:0] prev0, prev1;

   always @(negedge clk) begin
      if (!rst_n) stall0 = 1'b0;
      else begin
         if (stall0) begin
            chk("hold_valid0", 64'(tx0.tx_valid), 64'(1));
            chk("hold_data0", 64'(tx0.tx_data), 64'(prev0));
         end
         if (tx0.tx_valid && tx0.tx_ready) begin
            chk("byte_expected0", 64'(q0.size() != 0), 64'(1));
            if (q0.size() != 0) chk("byte0", 64'(tx0.tx_data), 64'(q0.pop_front()));
         end
         stall0 = tx0.tx_valid & ~tx0.tx_ready;
         prev0  = tx0.tx_data;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) stall1 = 1'b0;
      else begin
         if (stall1) chk("hold_data1", 64'(tx1.tx_data), 64'(prev1));
         if (tx1.tx_valid && tx1.tx_ready) begin
            chk("byte_expected1", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) chk("byte1", 64'(tx1.tx_data), 64'(q1.pop_front()));
         end
         stall1 = tx1.tx_valid & ~tx1.tx_ready;
         prev1  = tx1.tx_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int vc, nd;
      trig0 = 1'b0; halt0 = 1'b0; trig1 = 1'b0; bus0 = '0; bus1 = '0;
      tx0.tx_ready = 1'b0; tx1.tx_ready = 1'b1;

      // 1: reset with random inputs, then idle without requests
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         trig0 = 1'($urandom); halt0 = 1'($urandom); tx0.tx_ready = 1'($urandom);
         scramble_bus0();
         @(negedge clk);
         chk("rst_valid", 64'(tx0.tx_valid), 64'(0));
         chk("rst_data", 64'(tx0.tx_data), 64'(0));
         chk("rst_busy", 64'(busy0), 64'(0));
         chk("rst_done", 64'(done0), 64'(0));
         chk("rst_overrun", 64'(ovr0), 64'(0));
      end
      @(posedge clk); #1;
      trig0 = 1'b0; halt0 = 1'b0; tx0.tx_ready = 1'b1; rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_valid", 64'(tx0.tx_valid), 64'(0));
         chk("idle_busy", 64'(busy0), 64'(0));
      end

      // 2: incrementing words, ready always high
      for (int k = 0; k < NL0; k++) w0[k] = 32'h1000_0000 + 32'(k);
      load_bus0();
      push_frame0();
      pulse_trig0();
      chk("s2_first_valid", 64'(tx0.tx_valid), 64'(1));
      chk("s2_first_busy", 64'(busy0), 64'(1));
      chk("s2_first_byte", 64'(tx0.tx_data), 64'(8'hA5));
      run0(200, 1'b0, 1'b1, 1'b1, vc, nd);
      chk("s2_done_seen", 64'(nd), 64'(1));
      chk("s2_valid_cycles", 64'(vc), 64'(FRAME0));
      chk("s2_busy_after", 64'(busy0), 64'(0));
      chk("s2_done_after", 64'(done0), 64'(0));
      chk("s2_queue_empty", 64'(q0.size()), 64'(0));

      // 3: same frame, ready randomly low about 30% of cycles
      load_bus0();
      push_frame0();
      pulse_trig0();
      run0(1000, 1'b1, 1'b1, 1'b1, vc, nd);
      chk("s3_done_seen", 64'(nd), 64'(1));
      chk("s3_queue_empty", 64'(q0.size()), 64'(0));
      tx0.tx_ready = 1'b1;

      // 4a: halt held high gives exactly one frame
      for (int k = 0; k < NL0; k++) w0[k] = $urandom;
      load_bus0();
      push_frame0();
      @(posedge clk); #1 halt0 = 1'b1;
      run0(500, 1'b0, 1'b1, 1'b0, vc, nd);
      chk("s4_frames", 64'(nd), 64'(1));
      chk("s4_overrun_clear", 64'(ovr0), 64'(0));
      chk("s4_queue_empty", 64'(q0.size()), 64'(0));
      halt0 = 1'b0;

      // 4b: second trigger mid-dump sets overrun, snapshot unchanged
      for (int k = 0; k < NL0; k++) w0[k] = $urandom;
      load_bus0();
      push_frame0();
      pulse_trig0();
      run0(20, 1'b0, 1'b1, 1'b0, vc, nd);
      pulse_trig0();
      run0(200, 1'b0, 1'b1, 1'b1, vc, nd);
      chk("s4b_done_seen", 64'(nd), 64'(1));
      chk("s4b_overrun", 64'(ovr0), 64'(1));
      chk("s4b_queue_empty", 64'(q0.size()), 64'(0));

      // 5: 12-bit words, three latches
      bus1 = {12'hFFF, 12'h123, 12'hABC};
      q1.push_back(8'hA5); q1.push_back(8'h03);
      q1.push_back(8'hBC); q1.push_back(8'h0A);
      q1.push_back(8'h23); q1.push_back(8'h01);
      q1.push_back(8'hFF); q1.push_back(8'h0F);
      if (CS != 0) q1.push_back(8'hBC ^ 8'h0A ^ 8'h23 ^ 8'h01 ^ 8'hFF ^ 8'h0F);
      @(posedge clk); #1 trig1 = 1'b1;
      @(posedge clk); #1 trig1 = 1'b0;
      vc = 0; nd = 0;
      for (int i = 0; i < 50 && nd == 0; i++) begin
         @(negedge clk);
         if (tx1.tx_valid) vc++;
         if (done1) nd++;
      end
      chk("s5_done_seen", 64'(nd), 64'(1));
      chk("s5_valid_cycles", 64'(vc), 64'(FRAME1));
      chk("s5_queue_empty", 64'(q1.size()), 64'(0));
      chk("s5_overrun", 64'(ovr1), 64'(0));

      // 6: reset in the middle of the data phase
      for (int k = 0; k < NL0; k++) w0[k] = 32'hC0DE_0000 | 32'(k * 3);
      load_bus0();
      push_frame0();
      pulse_trig0();
      run0(10, 1'b0, 1'b0, 1'b0, vc, nd);
      chk("s6_pre_valid", 64'(tx0.tx_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("s6_async_valid", 64'(tx0.tx_valid), 64'(0));
      chk("s6_async_busy", 64'(busy0), 64'(0));
      chk("s6_async_overrun", 64'(ovr0), 64'(0));
      q0.delete();
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("s6_idle_valid", 64'(tx0.tx_valid), 64'(0));
      push_frame0();
      pulse_trig0();
      chk("s6_restart_byte", 64'(tx0.tx_data), 64'(8'hA5));
      run0(200, 1'b0, 1'b0, 1'b1, vc, nd);
      chk("s6_done_seen", 64'(nd), 64'(1));
      chk("s6_valid_cycles", 64'(vc), 64'(FRAME0));
      chk("s6_queue_empty", 64'(q0.size()), 64'(0));

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
